// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quad_pkg
// Description : Shared types and constants for the quadrature decoder:
//               AB state type, direction encodings, forward/reverse
//               next-state tables and lookup helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package quad_pkg;

    // Sampled {A,B} pair
    typedef logic [1:0] ab_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Next-state tables, indexed by the current {A,B} value (2 bits per entry,
    // entry for 2'b00 in bits [1:0]).
    // Forward : 00->10, 01->00, 10->11, 11->01
    localparam logic [7:0] c_FWD_NEXT = 8'b01_11_00_10;
    // Reverse : 00->01, 01->11, 10->00, 11->10
    localparam logic [7:0] c_REV_NEXT = 8'b10_00_11_01;

    function automatic ab_t fwd_next(input ab_t cur);
        return c_FWD_NEXT[{cur, 1'b0} +: 2];
    endfunction

    function automatic ab_t rev_next(input ab_t cur);
        return c_REV_NEXT[{cur, 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : quad_input_filter
// Description : Two-flop synchronizer followed by a consecutive-sample
//               filter. A value is accepted once it has been seen on
//               FILT_LEN consecutive cycles; o_vld pulses for one cycle
//               whenever a value is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_input_filter
    import quad_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_ab,
    output logic [1:0] o_ab,
    output logic       o_vld
);

    localparam logic [3:0] c_LEN = 4'(FILT_LEN);

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_prime;
    ab_t        r_cand;
    logic [3:0] r_cnt;
    ab_t        r_out;
    logic       r_vld;

    logic       w_same;
    logic [3:0] w_cnt_next;
    logic       w_accept;

    // Metastability synchronizer; r_prime tracks when r_sync2 holds a real sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_prime <= 2'b00;
        end else begin
            r_sync1 <= i_ab;
            r_sync2 <= r_sync1;
            r_prime <= {r_prime[0], 1'b1};
        end
    end

    // Run-length of the current candidate and acceptance on reaching FILT_LEN
    always_comb begin
        w_same     = (r_cnt != 4'd0) && (r_sync2 == r_cand);
        w_cnt_next = 4'd1;
        if (w_same) begin
            w_cnt_next = (r_cnt == c_LEN) ? c_LEN : r_cnt + 4'd1;
        end
        // Accept only on the cycle the run first reaches FILT_LEN
        w_accept = r_prime[1] && (w_cnt_next == c_LEN) && (!w_same || (r_cnt != c_LEN));
    end

    // Filter state and accepted output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= 2'b00;
            r_cnt  <= 4'd0;
            r_out  <= 2'b00;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (r_prime[1]) begin
                r_cand <= r_sync2;
                r_cnt  <= w_cnt_next;
                r_vld  <= w_accept;
                if (w_accept) begin
                    r_out <= r_sync2;
                end
            end
        end
    end

    assign o_ab  = r_out;
    assign o_vld = r_vld;

endmodule
`default_nettype wire

// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quadrature_decoder
// Description : Quadrature encoder decoder with input filtering, signed
//               wrapping position counter, illegal-transition detection
//               with saturating error count and windowed velocity.
// Revision    : 1.0 - initial release
// ============================================================================
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int FILT_LEN   = 3,
    parameter int VEL_WINDOW = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    A,
    input  logic                    B,
    input  logic                    clear,
    output logic signed [CNT_W-1:0] pos,
    output logic                    dir,
    output logic                    step,
    output logic                    err,
    output logic [7:0]              err_cnt,
    output logic signed [CNT_W-1:0] vel,
    output logic                    vel_valid
);

    localparam int                       c_WIN_W    = (VEL_WINDOW > 2) ? $clog2(VEL_WINDOW) : 1;
    localparam logic [c_WIN_W-1:0]       c_WIN_LAST = c_WIN_W'(VEL_WINDOW - 1);
    localparam logic [c_WIN_W-1:0]       c_WIN_ONE  = c_WIN_W'(1);
    localparam logic signed [CNT_W-1:0]  c_ONE      = CNT_W'(1);
    localparam logic signed [CNT_W-1:0]  c_MAX      = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0]  c_MIN      = {1'b1, {(CNT_W-1){1'b0}}};

    ab_t                      w_ab;
    logic                     w_vld;
    logic                     w_change;
    logic                     w_fwd;
    logic                     w_rev;
    logic                     w_ill;
    logic signed [CNT_W-1:0]  w_acc_next;

    ab_t                      r_ref;
    logic                     r_init;
    logic signed [CNT_W-1:0]  r_pos;
    logic                     r_dir;
    logic                     r_step;
    logic                     r_err;
    logic [7:0]               r_err_cnt;
    logic [c_WIN_W-1:0]       r_win_cnt;
    logic signed [CNT_W-1:0]  r_acc;
    logic signed [CNT_W-1:0]  r_vel;
    logic                     r_vel_valid;

    quad_input_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ab  ({A, B}),
        .o_ab  (w_ab),
        .o_vld (w_vld)
    );

    // Classify an accepted value against the reference state
    always_comb begin
        w_change = w_vld && r_init && (w_ab != r_ref);
        w_fwd    = w_change && (w_ab == fwd_next(r_ref));
        w_rev    = w_change && (w_ab == rev_next(r_ref));
        w_ill    = w_change && !w_fwd && !w_rev;
    end

    // Reference state, position, direction, step/error pulses, error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref     <= 2'b00;
            r_init    <= 1'b0;
            r_pos     <= '0;
            r_dir     <= DIR_FWD;
            r_step    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_step <= w_fwd || w_rev;
            r_err  <= w_ill;
            // The first accepted value after reset only seeds the reference
            if (w_vld) begin
                r_ref  <= w_ab;
                r_init <= 1'b1;
            end
            if (w_fwd) begin
                r_dir <= DIR_FWD;
            end else if (w_rev) begin
                r_dir <= DIR_REV;
            end
            // clear wins over a coincident step; direction still follows the step
            if (clear) begin
                r_pos <= '0;
            end else if (w_fwd) begin
                r_pos <= r_pos + c_ONE;
            end else if (w_rev) begin
                r_pos <= r_pos - c_ONE;
            end
            if (w_ill && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Saturating accumulation of this cycle's step
    always_comb begin
        w_acc_next = r_acc;
        if (w_fwd && (r_acc != c_MAX)) begin
            w_acc_next = r_acc + c_ONE;
        end else if (w_rev && (r_acc != c_MIN)) begin
            w_acc_next = r_acc - c_ONE;
        end
    end

    // Free-running window; the last cycle publishes the total and restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt   <= '0;
            r_acc       <= '0;
            r_vel       <= '0;
            r_vel_valid <= 1'b0;
        end else begin
            if (r_win_cnt == c_WIN_LAST) begin
                r_win_cnt   <= '0;
                r_vel       <= w_acc_next;
                r_vel_valid <= 1'b1;
                r_acc       <= '0;
            end else begin
                r_win_cnt   <= r_win_cnt + c_WIN_ONE;
                r_vel_valid <= 1'b0;
                r_acc       <= w_acc_next;
            end
        end
    end

    assign pos       = r_pos;
    assign dir       = r_dir;
    assign step      = r_step;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;
    assign vel       = r_vel;
    assign vel_valid = r_vel_valid;

endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_quadrature_decoder
// Description : Scoreboard bench for quadrature_decoder. The driver pushes
//               expected step/err events and velocity values; a monitor
//               pops and compares them when the DUT pulses.
//               CNT_W=8 keeps the wrap boundary reachable (127 -> -128).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quadrature_decoder;

    localparam int CW = 8;
    localparam int FL = 3;
    localparam int VW = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic A     = 1'b1;
    logic B     = 1'b1;
    logic clear = 1'b0;
    logic signed [CW-1:0] pos;
    logic signed [CW-1:0] vel;
    logic       dir;
    logic       step;
    logic       err;
    logic       vel_valid;
    logic [7:0] err_cnt;

    typedef struct {
        int kind;   // 1 = step, 2 = err
        int pos;
        int dir;
        int ecnt;
        int at;
    } ev_t;

    ev_t evq[$];
    int  velq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_steps  = 0;
    int cyc      = 0;
    int last_vv  = -1;

    int         m_pos  = 0;
    int         m_dir  = 0;
    int         m_ecnt = 0;
    logic [1:0] m_ref  = 2'b00;
    bit         m_init = 1'b0;

    quadrature_decoder #(
        .CNT_W      (CW),
        .FILT_LEN   (FL),
        .VEL_WINDOW (VW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .clear     (clear),
        .pos       (pos),
        .dir       (dir),
        .step      (step),
        .err       (err),
        .err_cnt   (err_cnt),
        .vel       (vel),
        .vel_valid (vel_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] f_fwd(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] f_rev(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int wrapc(input int x);
        logic signed [CW-1:0] t;
        t = CW'(x);
        return int'(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every step/err pulse and armed velocity update
    always @(negedge clk) begin
        ev_t e;
        int  ev;
        if (!rst_n) begin
            last_vv = -1;
        end else begin
            if (step) n_steps++;
            if (step || err) begin
                if (evq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: step=%0b err=%0b pos=%0d, required no event", step, err, pos);
                end else begin
                    e = evq.pop_front();
                    chk("ev_kind", (step ? 1 : 0) + (err ? 2 : 0), e.kind);
                    chk("ev_pos", int'(pos), e.pos);
                    chk("ev_dir", int'(dir), e.dir);
                    chk("ev_err_cnt", int'(err_cnt), e.ecnt);
                    chk("ev_latency", cyc, e.at);
                end
            end
            if (vel_valid) begin
                if (velq.size() > 0) begin
                    ev = velq.pop_front();
                    chk("vel", int'(vel), ev);
                    if (last_vv >= 0) chk("vel_period", cyc - last_vv, VW);
                end
                last_vv = cyc;
            end
        end
    end

    // Drive {A,B}=v for hold cycles; model predicts the resulting event.
    // With clr, clear is raised exactly in the cycle the step commits.
    task automatic drive(input logic [1:0] v, input int hold, input bit clr);
        int t0;
        @(posedge clk);
        #1;
        {A, B} = v;
        t0 = cyc;
        if (!m_init) begin
            m_init = 1'b1;
        end else if (v != m_ref) begin
            if (v == f_fwd(m_ref)) begin
                m_pos = clr ? 0 : wrapc(m_pos + 1);
                m_dir = 0;
                evq.push_back('{1, m_pos, 0, m_ecnt, t0 + FL + 3});
            end else if (v == f_rev(m_ref)) begin
                m_pos = clr ? 0 : wrapc(m_pos - 1);
                m_dir = 1;
                evq.push_back('{1, m_pos, 1, m_ecnt, t0 + FL + 3});
            end else begin
                if (m_ecnt < 255) m_ecnt++;
                evq.push_back('{2, m_pos, m_dir, m_ecnt, t0 + FL + 3});
            end
        end
        m_ref = v;
        if (clr) begin
            repeat (FL + 2) @(posedge clk);
            #1 clear = 1'b1;
            @(posedge clk);
            #1 clear = 1'b0;
            repeat (hold - FL - 4) @(posedge clk);
        end else begin
            repeat (hold - 1) @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without a clock edge
    task automatic do_reset(input logic [1:0] v);
        chk("queue_empty_before_reset", evq.size(), 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        {A, B} = v;
        #1;
        chk("async_rst_pos", int'(pos), 0);
        chk("async_rst_err_cnt", int'(err_cnt), 0);
        chk("async_rst_vel", int'(vel), 0);
        chk("async_rst_dir", int'(dir), 0);
        m_pos  = 0;
        m_dir  = 0;
        m_ecnt = 0;
        m_init = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int s0;
        int guard;

        // Reset state with A=B=1, then hold 11 for 50 cycles after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pos", int'(pos), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_vel", int'(vel), 0);
        chk("rst_vel_valid", int'(vel_valid), 0);
        #1 rst_n = 1'b1;
        drive(2'b11, 50, 1'b0);
        idle(2);
        chk("hold11_pos", int'(pos), 0);
        chk("hold11_steps", n_steps, 0);
        chk("hold11_err_cnt", int'(err_cnt), 0);

        // Eight forward transitions from 00, 10 cycles each
        do_reset(2'b00);
        drive(2'b00, 10, 1'b0);
        s0 = n_steps;
        for (int i = 0; i < 8; i++) begin
            drive(f_fwd(m_ref), 10, 1'b0);
        end
        idle(8);
        chk("fwd8_pos", int'(pos), 8);
        chk("fwd8_dir", int'(dir), 0);
        chk("fwd8_steps", n_steps - s0, 8);

        // Twelve reverse transitions with a one-cycle glitch on A in one hold
        for (int i = 0; i < 12; i++) begin
            drive(f_rev(m_ref), 10, 1'b0);
            if (i == 5) begin
                idle(1);
                chk("pre_glitch_pos", int'(pos), m_pos);
                @(posedge clk);
                #1 A = ~A;
                @(posedge clk);
                #1 A = ~A;
                idle(10);
                chk("post_glitch_pos", int'(pos), m_pos);
            end
        end
        idle(8);
        chk("rev12_pos", int'(pos), -4);
        chk("rev12_dir", int'(dir), 1);

        // Illegal 00 -> 11, then saturate the error counter
        drive(2'b11, 10, 1'b0);
        idle(8);
        chk("ill1_err_cnt", int'(err_cnt), 1);
        chk("ill1_pos", int'(pos), -4);
        for (int i = 0; i < 299; i++) begin
            drive((m_ref == 2'b11) ? 2'b00 : 2'b11, 5, 1'b0);
        end
        idle(8);
        chk("ill300_err_cnt", int'(err_cnt), 255);
        chk("ill300_pos", int'(pos), -4);
        chk("ill300_dir", int'(dir), 1);

        // Wrap at the positive limit and back
        guard = 0;
        while ((m_pos != 127) && (guard < 300)) begin
            drive(f_fwd(m_ref), 4, 1'b0);
            guard++;
        end
        idle(8);
        chk("at_max_pos", int'(pos), 127);
        drive(f_fwd(m_ref), 10, 1'b0);
        idle(2);
        chk("wrap_fwd_pos", int'(pos), -128);
        chk("wrap_fwd_dir", int'(dir), 0);
        drive(f_rev(m_ref), 10, 1'b0);
        idle(2);
        chk("wrap_rev_pos", int'(pos), 127);
        chk("wrap_rev_dir", int'(dir), 1);

        // clear coincident with a forward step
        s0 = n_steps;
        drive(f_fwd(m_ref), 12, 1'b1);
        idle(4);
        chk("clr_pos", int'(pos), 0);
        chk("clr_steps", n_steps - s0, 1);
        chk("clr_dir", int'(dir), 0);
        chk("clr_err_cnt", int'(err_cnt), 255);

        // Velocity: one transition per 10 cycles forward, then reverse
        for (int i = 0; i < 40; i++) begin
            if ((i == 15) || (i == 25)) velq.push_back(10);
            drive(f_fwd(m_ref), 10, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            if ((i == 15) || (i == 25)) velq.push_back(-10);
            drive(f_rev(m_ref), 10, 1'b0);
        end
        idle(20);
        chk("vel_final_pos", int'(pos), 0);
        chk("events_drained", evq.size(), 0);
        chk("vel_drained", velq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the signed position and velocity outputs.
REQ-002 Parameter FILT_LEN, default 3, SHALL set the number of consecutive identical synchronized samples required to accept a new A/B value (range 1..15).
REQ-003 Parameter VEL_WINDOW, default 100000, SHALL set the velocity measurement window in clk cycles (at least 2).
REQ-004 clk  in  1  the single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 A, B  in  1 each  asynchronous quadrature inputs from the motor encoder.
REQ-007 clear  in  1  synchronous, active-high position clear.
REQ-008 pos  out  CNT_W signed  accumulated position in quadrature counts.
REQ-009 dir  out  1  direction of the last valid step: 0 = clockwise/forward, 1 = counter-clockwise/reverse.
REQ-010 step  out  1  one-cycle pulse on each valid accepted transition.
REQ-011 err  out  1  one-cycle pulse on each illegal transition.
REQ-012 err_cnt  out  8  saturating count of illegal transitions.
REQ-013 vel  out  CNT_W signed  net counts in the last completed window.
REQ-014 vel_valid  out  1  one-cycle pulse when vel is updated.

Function
REQ-015 A and B SHALL each pass through a two-flop synchronizer.
- A synchronized A/B pair SHALL be accepted only after it is identical for FILT_LEN consecutive cycles.
- Shorter glitches SHALL be ignored.
REQ-016 Forward sequence of accepted {A,B} is 00→10→11→01→00.
- Each forward transition SHALL increment pos by 1 and set dir=0.
REQ-017 Reverse sequence is 00→01→11→10→00.
- Each reverse transition SHALL decrement pos by 1 and set dir=1.
REQ-018 An accepted change of both bits at once is illegal. It SHALL:
- pulse err;
- increment err_cnt, saturating at 255;
- leave pos and dir unchanged;
- adopt the new value as the reference state.
REQ-019 pos, dir, step and err SHALL update on the cycle after acceptance.
- Input edge to pos change SHALL be exactly FILT_LEN+3 cycles for a clean edge.
REQ-020 pos SHALL wrap in two's complement: +max forward → −2^(CNT_W−1), and the inverse.
REQ-021 clear SHALL set pos to 0 on the next edge and take priority over a simultaneous step.
- In that case step still pulses and dir still updates.
- clear SHALL NOT affect err_cnt or velocity.
REQ-022 Initialization after reset:
- The first accepted value SHALL initialize the reference state only.
- It SHALL produce no step and no err.
REQ-023 Velocity measurement:
- A free-running counter SHALL mark windows of VEL_WINDOW cycles.
- A signed accumulator SHALL sum ±1 steps, saturating at the CNT_W limits.
- In the last cycle of a window, vel SHALL load the accumulator including that cycle's step, vel_valid SHALL pulse, and the accumulator SHALL restart from 0.

Reset
REQ-024 On rst_n low, all of the following SHALL be 0 asynchronously:
- outputs: pos, dir, step, err, err_cnt, vel, vel_valid;
- internal state: synchronizers, filter, window counter, accumulator, init flag.
REQ-025 Reset asserted mid-count SHALL abandon the current window.
- After release, the first accepted value SHALL follow REQ-022.

Structure
REQ-026 Package quad_pkg SHALL hold:
- the 2-bit AB state type;
- DIR_FWD=0 and DIR_REV=1;
- the forward and reverse next-state constants.
REQ-027 Synchronizer plus filter SHALL be one sub-module, quad_input_filter (2-bit wide, parameter FILT_LEN).
- Decode, position, error and velocity logic SHALL stay in quadrature_decoder.

Verification
REQ-028 Reset release with A=B=1 held for 50 cycles → pos=0, step never pulses, err=0.
REQ-029 Defaults: A/B = 00, 10, 11, 01 repeated, each held 10 cycles, 8 transitions total → pos=8, dir=0, 8 step pulses, each FILT_LEN+3 cycles after its edge.
REQ-030 Then 12 reverse transitions → pos=−4, dir=1.
- A 1-cycle glitch on A mid-hold → no pos change.
REQ-031 Accepted 00→11 → one err pulse, err_cnt=1, pos unchanged.
- 300 illegal transitions → err_cnt=255.
REQ-032 Wrap and clear:
- pos=32767 (CNT_W=16), one forward step → pos=−32768.
- clear coincident with a step → pos=0, step pulses.
REQ-033 VEL_WINDOW=100, forward transition every 10 cycles → vel=10, vel_valid every 100 cycles.
- After reversing direction, vel settles at −10.
